// File: rtl/sieve_sram_arbiter_pkg.sv
// Shared defaults and FSM encoding for the sieve SRAM arbiter and its storage.
package sieve_sram_arbiter_pkg;

  localparam int   DEPTH_DEF      = 1021;
  localparam int   AW_DEF         = 10;
  localparam logic FILL_VALUE_DEF = 1'b1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sieve_sram_arbiter_sram_1p.sv
// Single-port 1-bit SRAM: write on enable+we, otherwise synchronous read with 1-cycle latency.
// No flow control; contents are never reset, rdata holds between reads.
module sram_1p
  import sieve_sram_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/sieve_sram_arbiter.sv
// Two-port round-robin arbiter in front of a 1-bit SRAM with a power-up/on-demand fill; grants are
// same-cycle, read data lands one cycle later; requests are held off (not dropped) while filling.
module sieve_sram_arbiter
  import sieve_sram_arbiter_pkg::*;
#(
  parameter int   DEPTH      = DEPTH_DEF,
  parameter int   AW         = AW_DEF,
  parameter logic FILL_VALUE = FILL_VALUE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic          a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic          a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic          b_rdata,
  output logic          busy,
  output logic          fill_done
);

  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] fill_addr;
  logic          last_b;
  logic          rd_hit;
  logic          run;
  logic [AW-1:0] acc_addr;
  logic          acc_hit;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic          sram_wdata;
  logic          sram_rdata;

  always_comb begin
    run        = (state == S_RUN);
    a_gnt      = run & a_req & (~b_req | last_b);
    b_gnt      = run & b_req & ~a_gnt;
    acc_addr   = a_gnt ? a_addr : b_addr;
    acc_hit    = ({1'b0, acc_addr} < DEPTH_X);
    sram_en    = 1'b1;
    sram_we    = 1'b1;
    sram_addr  = fill_addr;
    sram_wdata = FILL_VALUE;
    if (run) begin
      // Out-of-range accesses are granted but never touch the array.
      sram_en    = (a_gnt | b_gnt) & acc_hit;
      sram_we    = a_gnt & a_we;
      sram_addr  = acc_addr;
      sram_wdata = a_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FILL;
      fill_addr <= '0;
      busy      <= 1'b1;
      fill_done <= 1'b0;
      last_b    <= 1'b1;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      rd_hit    <= 1'b0;
    end else begin
      a_rvalid  <= a_gnt & ~a_we;
      b_rvalid  <= b_gnt;
      rd_hit    <= acc_hit;
      fill_done <= 1'b0;
      if (a_gnt | b_gnt) last_b <= b_gnt;
      if (fill) begin
        state     <= S_FILL;
        fill_addr <= '0;
        busy      <= 1'b1;
      end else if (state == S_FILL) begin
        if (fill_addr == LAST_ADDR) begin
          state     <= S_RUN;
          fill_addr <= '0;
          busy      <= 1'b0;
          fill_done <= 1'b1;
        end else begin
          fill_addr <= fill_addr + AW'(1);
        end
      end
    end
  end

  assign a_rdata = a_rvalid & rd_hit & sram_rdata;
  assign b_rdata = b_rvalid & rd_hit & sram_rdata;

  sram_1p #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_sieve_sram_arbiter.sv
// Directed bench for sieve_sram_arbiter: fill timing, round-robin, read/write latency, range guard, refill and reset abort.
module tb_sieve_sram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       fill;
  logic       a_req;
  logic       a_we;
  logic [9:0] a_addr;
  logic       a_wdata;
  logic       a_gnt;
  logic       a_rvalid;
  logic       a_rdata;
  logic       b_req;
  logic [9:0] b_addr;
  logic       b_gnt;
  logic       b_rvalid;
  logic       b_rdata;
  logic       busy;
  logic       fill_done;

  int   checks = 0;
  int   errors = 0;
  int   bad;
  logic exp_mem [1021];

  always #5 clk = ~clk;

  sieve_sram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .fill      (fill),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .busy      (busy),
    .fill_done (fill_done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Streams B reads over the whole array, one per cycle, against exp_mem.
  task automatic scan_b(output int nbad);
    nbad  = 0;
    b_req = 1'b1;
    for (int i = 0; i < 1021; i++) begin
      b_addr = 10'(i);
      #1;
      if (b_gnt !== 1'b1) nbad++;
      tick();
      if (b_rvalid !== 1'b1 || b_rdata !== exp_mem[i]) nbad++;
    end
    b_req  = 1'b0;
    b_addr = '0;
  endtask

  initial begin
    reset = 1'b1; fill = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = 1'b0;
    b_req = 1'b0; b_addr = '0;
    for (int i = 0; i < 1021; i++) exp_mem[i] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_fill_done", fill_done, 1'b0);
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk1("rst_a_rdata", a_rdata, 1'b0);
    chk1("rst_b_rdata", b_rdata, 1'b0);

    // Power-up fill: busy through 1020 edges, done on edge 1021.
    reset = 1'b0;
    bad = 0;
    for (int i = 1; i <= 1020; i++) begin
      tick();
      if (busy !== 1'b1 || fill_done !== 1'b0) bad++;
    end
    chkn("fill_busy_cycles", bad, 0);
    tick();
    chk1("fill_done_pulse", fill_done, 1'b1);
    chk1("fill_busy_drop", busy, 1'b0);
    tick();
    chk1("fill_done_one_cycle", fill_done, 1'b0);

    scan_b(bad);
    chkn("scan_after_reset_fill", bad, 0);

    // Conflict: last served was B, so A,B,A,B,A,B.
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd7;
    b_req = 1'b1; b_addr = 10'd8;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1("rr_a_gnt", a_gnt, (k % 2) == 0);
      chk1("rr_b_gnt", b_gnt, (k % 2) == 1);
      tick();
      chk1("rr_a_rdata", a_rdata, (k % 2) == 0);
      chk1("rr_b_rdata", b_rdata, (k % 2) == 1);
    end
    a_req = 1'b0; b_req = 1'b0;

    // A writes 0 at 4, B reads it back the next cycle.
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd4; a_wdata = 1'b0;
    #1;
    chk1("wr4_a_gnt", a_gnt, 1'b1);
    tick();
    exp_mem[4] = 1'b0;
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_addr = 10'd4;
    #1;
    chk1("wr4_no_rvalid", a_rvalid, 1'b0);
    chk1("rd4_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    chk1("rd4_b_rvalid", b_rvalid, 1'b1);
    chk1("rd4_b_rdata", b_rdata, 1'b0);

    // Out-of-range accesses.
    b_req = 1'b1; b_addr = 10'd1021;
    #1;
    chk1("oob_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    chk1("oob_b_rvalid", b_rvalid, 1'b1);
    chk1("oob_b_rdata", b_rdata, 1'b0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd1023; a_wdata = 1'b0;
    #1;
    chk1("oob_wr_gnt", a_gnt, 1'b1);
    tick();
    a_we = 1'b0;
    #1;
    chk1("oob_rd_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("oob_a_rvalid", a_rvalid, 1'b1);
    chk1("oob_a_rdata", a_rdata, 1'b0);
    scan_b(bad);
    chkn("scan_after_oob_write", bad, 0);

    // Clear entries 0 and 1020, confirm, then refill with A pending.
    a_req = 1'b1; a_we = 1'b1; a_wdata = 1'b0; a_addr = 10'd0;
    tick();
    a_addr = 10'd1020;
    tick();
    exp_mem[0] = 1'b0; exp_mem[1020] = 1'b0;
    a_we = 1'b0;
    tick();
    a_req = 1'b0;
    chk1("clr1020_rvalid", a_rvalid, 1'b1);
    chk1("clr1020_rdata", a_rdata, 1'b0);

    fill = 1'b1;
    tick();
    fill = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd1020;
    chk1("refill_busy", busy, 1'b1);
    bad = 0;
    for (int i = 1; i <= 1021; i++) begin
      #1;
      if (a_gnt !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    chkn("refill_a_held_off", bad, 0);
    #1;
    chk1("refill_first_run_gnt", a_gnt, 1'b1);
    chk1("refill_done", fill_done, 1'b1);
    chk1("refill_busy_low", busy, 1'b0);
    tick();
    a_req = 1'b0;
    chk1("refill_a_rvalid", a_rvalid, 1'b1);
    chk1("refill_a_rdata", a_rdata, 1'b1);
    for (int i = 0; i < 1021; i++) exp_mem[i] = 1'b1;
    scan_b(bad);
    chkn("scan_after_refill", bad, 0);

    // Reset lands at fill_addr 500; a full fill must follow release.
    fill = 1'b1;
    tick();
    fill = 1'b0;
    repeat (500) tick();
    reset = 1'b1;
    #1;
    chk1("midfill_rst_busy", busy, 1'b1);
    chk1("midfill_rst_done", fill_done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 1; i <= 1020; i++) begin
      tick();
      if (busy !== 1'b1 || fill_done !== 1'b0) bad++;
    end
    chkn("midfill_full_refill", bad, 0);
    tick();
    chk1("midfill_done_pulse", fill_done, 1'b1);
    chk1("midfill_busy_drop", busy, 1'b0);
    scan_b(bad);
    chkn("scan_after_midfill_reset", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
